// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time in CLK cycles, strobes VALID per
// completed period, and flags a stuck input (no rising edge within TIMEOUT).
//
// state   | meaning
// IDLE    | not armed; waiting for a first rise (after reset or after a timeout)
// MEASURE | armed; each rise publishes the period that just ended
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 10000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH,
  output logic             VALID,
  output logic             STUCK,
  output logic             LEVEL
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_s1, r_s2, r_s3;
  logic [1:0]       r_mask_cnt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hcnt;
  logic             w_mask_done;
  logic             w_rise;
  logic             w_at_to;
  logic             w_publish;
  logic             w_arm;
  logic             w_timeout;

  // Masking the first 3 cycles hides the s2/s3 transition of a pin held high through reset.
  assign w_mask_done = (r_mask_cnt == 2'd3);
  assign w_rise      = r_s2 & ~r_s3 & w_mask_done;
  assign w_at_to     = (r_cnt == TO);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_s3       <= 1'b0;
      r_mask_cnt <= 2'd0;
    end else begin
      r_s1 <= PWM_IN;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (!w_mask_done) r_mask_cnt <= r_mask_cnt + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt  <= '0;
      r_hcnt <= '0;
    end else if (w_rise) begin
      r_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
      r_hcnt <= {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (!w_at_to) begin
      r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      r_hcnt <= r_hcnt + {{(CNT_W-1){1'b0}}, r_s2};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_state_nxt = MEASURE;
      MEASURE: if (w_at_to && !w_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A rise on the timeout cycle wins over the timeout.
  always_comb begin
    w_publish = 1'b0;
    w_arm     = 1'b0;
    w_timeout = w_at_to && !w_rise;
    case (r_state)
      IDLE:    w_arm     = w_rise;
      MEASURE: w_publish = w_rise;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PERIOD <= '0;
      HIGH   <= '0;
      VALID  <= 1'b0;
      STUCK  <= 1'b0;
      LEVEL  <= 1'b0;
    end else begin
      VALID <= w_publish;
      if (w_publish) begin
        PERIOD <= r_cnt;
        HIGH   <= r_hcnt;
      end
      if (w_arm) begin
        STUCK <= 1'b0;
      end else if (w_timeout) begin
        STUCK <= 1'b1;
        LEVEL <= r_s2;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM patterns, queues the expected
// measurement at each rise and compares it when VALID strobes.
module tb_pwm_capture;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 10000;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             PWM_IN = 1'b0;
  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] HIGH;
  logic             VALID;
  logic             STUCK;
  logic             LEVEL;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .PWM_IN(PWM_IN),
    .PERIOD(PERIOD), .HIGH(HIGH), .VALID(VALID), .STUCK(STUCK), .LEVEL(LEVEL)
  );

  always #5 CLK = ~CLK;

  typedef struct {int p; int h;} meas_t;

  meas_t q[$];
  meas_t m;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  int    n_valid = 0;
  int    stuck_seen = 0;
  bit    have_prev = 1'b0;
  int    prev_p, prev_h, last_rise, t_rel, nv0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle(int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Each rise closes the previous period, so its measurement is queued here.
  task automatic drive_pwm(int p, int h, int n);
    for (int k = 0; k < n; k++) begin
      if (have_prev) q.push_back('{prev_p, prev_h});
      prev_p = p; prev_h = h; have_prev = 1'b1; last_rise = cyc;
      PWM_IN = 1'b1; cycle(h);
      PWM_IN = 1'b0; cycle(p - h);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_period"}, int'(PERIOD), 0);
    check({tag, "_high"},   int'(HIGH), 0);
    check({tag, "_valid"},  int'(VALID), 0);
    check({tag, "_stuck"},  int'(STUCK), 0);
    check({tag, "_level"},  int'(LEVEL), 0);
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (STUCK) stuck_seen++;
      if (VALID) begin
        n_valid++;
        check("valid_expected", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          m = q.pop_front();
          check("period", int'(PERIOD), m.p);
          check("high", int'(HIGH), m.h);
        end
      end
    end
  end

  initial begin
    // reset state
    cycle(3);
    check_reset_outputs("rst");
    RST = 1'b1;
    cycle(5);

    // lock at 2450/1000: 5 rises give 4 measurements
    drive_pwm(2450, 1000, 5);
    check("t1_valid_count", n_valid, 4);
    check("t1_queue_empty", q.size(), 0);

    // duty steps to 2449 then 1
    drive_pwm(2450, 2449, 1);
    drive_pwm(2450, 1, 2);
    check("t2_queue_empty", q.size(), 0);

    // hold low until timeout
    have_prev = 1'b0;
    nv0 = n_valid;
    while (cyc < last_rise + 3 + TIMEOUT - 1) cycle();
    check("t3_stuck_before_to", int'(STUCK), 0);
    cycle();
    check("t3_stuck_at_to", int'(STUCK), 1);
    check("t3_level", int'(LEVEL), 0);
    check("t3_no_valid", n_valid, nv0);
    drive_pwm(2450, 1000, 1);
    check("t3_stuck_cleared", int'(STUCK), 0);
    check("t3_rearm_no_valid", n_valid, nv0);
    drive_pwm(2450, 1000, 1);
    check("t3_first_valid", n_valid, nv0 + 1);

    // pin held high through reset
    PWM_IN = 1'b1;
    cycle(2);
    RST = 1'b0;
    cycle(2);
    check_reset_outputs("t4_rst");
    RST = 1'b1;
    t_rel = cyc;
    have_prev = 1'b0;
    q.delete();
    nv0 = n_valid;
    while (cyc < t_rel + TIMEOUT) cycle();
    check("t4_stuck_before_to", int'(STUCK), 0);
    cycle();
    check("t4_stuck_at_to", int'(STUCK), 1);
    check("t4_level", int'(LEVEL), 1);
    while (cyc < t_rel + 20000) cycle();
    check("t4_no_valid", n_valid, nv0);
    check("t4_stuck_held", int'(STUCK), 1);

    // reset mid-period during lock
    PWM_IN = 1'b0;
    cycle(10);
    drive_pwm(2450, 1000, 2);
    q.push_back('{prev_p, prev_h});
    PWM_IN = 1'b1;
    cycle(500);
    RST = 1'b0;
    cycle(1);
    check_reset_outputs("t5_rst");
    cycle(1);
    RST = 1'b1;
    have_prev = 1'b0;
    nv0 = n_valid;
    cycle(500);
    PWM_IN = 1'b0;
    cycle(1450);
    drive_pwm(2450, 1000, 1);
    check("t5_rearm_no_valid", n_valid, nv0);
    drive_pwm(2450, 1000, 1);
    check("t5_first_valid", n_valid, nv0 + 1);
    check("t5_queue_empty", q.size(), 0);

    // period exactly TIMEOUT
    stuck_seen = 0;
    drive_pwm(TIMEOUT, 5000, 2);
    q.push_back('{prev_p, prev_h});
    have_prev = 1'b0;
    PWM_IN = 1'b1;
    cycle(5);
    PWM_IN = 1'b0;
    cycle(10);
    check("t6_period", int'(PERIOD), TIMEOUT);
    check("t6_queue_empty", q.size(), 0);
    check("t6_stuck_never", stuck_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
